// File: rtl/blood_sprite_renderer_pkg.sv
// Shared definitions for the blood-splash sprite renderer: sprite geometry,
// animation timing, colour key, FSM state encoding and screen limits.
// Optional feature macro used by the renderer: BLOOD_MIRROR_EN.
package blood_sprite_renderer_pkg;

    // Sprite geometry; ROM row/col address width follows the edge size.
    localparam int SPRITE_SIZE = 64;
    localparam int SPRITE_AW   = $clog2(SPRITE_SIZE);

    // Animation timing.
    localparam int NUM_FRAMES  = 8;
    localparam int FRAME_W     = $clog2(NUM_FRAMES);
    localparam int HOLD_TICKS  = 4;
    localparam int HOLD_W      = $clog2(HOLD_TICKS);

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);

    // Screen coordinates and colour.
    localparam int COORD_W  = 10;
    localparam int DATA_W   = 12;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // ROM colour treated as see-through.
    localparam logic [DATA_W-1:0] TRANSPARENT = 12'h000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } anim_state_t;

    // True when coord lies in [base, base+SPRITE_SIZE). Evaluated one bit wider
    // than the coordinate so a sprite placed near 1023 does not wrap to column 0.
    function automatic logic in_span(input logic [COORD_W-1:0] coord,
                                     input logic [COORD_W-1:0] base);
        logic [COORD_W:0] c_ext;
        logic [COORD_W:0] b_ext;
        c_ext = {1'b0, coord};
        b_ext = {1'b0, base};
        return (c_ext >= b_ext) && (c_ext < (b_ext + (COORD_W+1)'(SPRITE_SIZE)));
    endfunction

endpackage

// File: rtl/blood_sprite_renderer_anim_fsm.sv
// Animation controller for the blood-splash sprite: play/idle state, hold
// counter, frame index and the screen position latched on trigger.
module blood_anim_fsm
    import blood_sprite_renderer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               trigger,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] trig_x,
    input  logic [COORD_W-1:0] trig_y,
    input  logic               facing,
    output logic               busy,
    output logic [FRAME_W-1:0] frame,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               facing_q
);

    anim_state_t        state_q, state_n;
    logic [HOLD_W-1:0]  hold_q,  hold_n;
    logic [FRAME_W-1:0] frame_q, frame_n;
    logic [COORD_W-1:0] px_q,    px_n;
    logic [COORD_W-1:0] py_q,    py_n;
    logic               face_q,  face_n;

    // State and animation registers; all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            frame_q <= '0;
            px_q    <= '0;
            py_q    <= '0;
            face_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            hold_q  <= hold_n;
            frame_q <= frame_n;
            px_q    <= px_n;
            py_q    <= py_n;
            face_q  <= face_n;
        end
    end

    // Next-state logic: trigger (re)starts from frame 0 and takes priority over
    // a same-cycle frame_tick; ticks advance hold, then frame, then finish.
    always_comb begin
        state_n = state_q;
        hold_n  = hold_q;
        frame_n = frame_q;
        px_n    = px_q;
        py_n    = py_q;
        face_n  = face_q;
        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_n = ST_PLAY;
                    px_n    = trig_x;
                    py_n    = trig_y;
                    face_n  = facing;
                    frame_n = '0;
                    hold_n  = '0;
                end
            end
            ST_PLAY: begin
                if (trigger) begin
                    px_n    = trig_x;
                    py_n    = trig_y;
                    face_n  = facing;
                    frame_n = '0;
                    hold_n  = '0;
                end else if (frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_n = '0;
                        if (frame_q == FRAME_LAST) begin
                            state_n = ST_IDLE;
                            frame_n = '0;
                        end else begin
                            frame_n = frame_q + 1'b1;
                        end
                    end else begin
                        hold_n = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == ST_PLAY);
    assign frame    = frame_q;
    assign pos_x    = px_q;
    assign pos_y    = py_q;
    assign facing_q = face_q;

endmodule

// File: rtl/blood_sprite_renderer.sv
// Blood-splash sprite renderer: drives the 64x64 frame ROM address from the
// VGA pixel position, aligns the hit flag to the ROM's one-cycle latency and
// emits the colour-keyed overlay pixel two clocks after x/y.
// Optional feature macro: BLOOD_MIRROR_EN (horizontal mirroring by facing).
module blood_sprite_renderer
    import blood_sprite_renderer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        trigger,
    input  logic [9:0]  trig_x,
    input  logic [9:0]  trig_y,
    input  logic        facing,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    output logic [2:0]  rom_frame,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb_out,
    output logic        blood_on,
    output logic        busy
);

    logic               anim_busy;
    logic [FRAME_W-1:0] anim_frame;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               facing_q;

    blood_anim_fsm u_anim (
        .clk        (clk),
        .reset      (reset),
        .trigger    (trigger),
        .frame_tick (frame_tick),
        .trig_x     (trig_x),
        .trig_y     (trig_y),
        .facing     (facing),
        .busy       (anim_busy),
        .frame      (anim_frame),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .facing_q   (facing_q)
    );

    // Keyed colour: pass opaque ROM data for an in-sprite pixel, else black.
    function automatic logic [DATA_W-1:0] key_pixel(input logic vld,
                                                    input logic [DATA_W-1:0] data);
        return (vld && (data != TRANSPARENT)) ? data : '0;
    endfunction

    // Stage p0: combinational hit test and ROM addressing from the live x/y.
    logic                 hit_p0;
    logic [SPRITE_AW-1:0] row_off_p0;
    logic [SPRITE_AW-1:0] col_off_p0;
    logic [SPRITE_AW-1:0] col_addr_p0;

    assign hit_p0 = anim_busy && in_span(x, pos_x) && in_span(y, pos_y);

    // Only the low address bits of the offsets matter; inside the window the
    // full difference is below SPRITE_SIZE, so truncated subtraction is exact.
    assign row_off_p0 = y[SPRITE_AW-1:0] - pos_y[SPRITE_AW-1:0];
    assign col_off_p0 = x[SPRITE_AW-1:0] - pos_x[SPRITE_AW-1:0];

`ifdef BLOOD_MIRROR_EN
    // SPRITE_SIZE-1-offset is the bitwise complement for a power-of-two edge.
    assign col_addr_p0 = facing_q ? ~col_off_p0 : col_off_p0;
`else
    logic unused_facing;
    assign unused_facing = facing_q;
    assign col_addr_p0   = col_off_p0;
`endif

    // Address is parked at 0 outside the sprite so idle/reset reads are stable.
    assign rom_row   = hit_p0 ? row_off_p0  : '0;
    assign rom_col   = hit_p0 ? col_addr_p0 : '0;
    assign rom_frame = anim_frame;
    assign busy      = anim_busy;

    // Stage p1: hit qualified by video_on, delayed to meet the ROM read data.
    logic vld_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= hit_p0 && video_on;
        end
    end

    // Stage p2: colour key against the ROM output and register the overlay.
    always_ff @(posedge clk) begin
        if (reset) begin
            blood_on <= 1'b0;
            rgb_out  <= '0;
        end else begin
            blood_on <= vld_p1 && (rom_data != TRANSPARENT);
            rgb_out  <= key_pixel(vld_p1, rom_data);
        end
    end

endmodule

// File: tb/tb_blood_sprite_renderer.sv
// Directed bench for blood_sprite_renderer with a registered ROM model and a
// scoreboard of expected overlay pixels released two clocks after each pixel.
module tb_blood_sprite_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        video_on = 1'b0;
    logic        frame_tick = 1'b0;
    logic        trigger = 1'b0;
    logic [9:0]  trig_x = '0;
    logic [9:0]  trig_y = '0;
    logic        facing = 1'b0;
    logic [5:0]  rom_row;
    logic [5:0]  rom_col;
    logic [2:0]  rom_frame;
    logic [11:0] rom_data = '0;
    logic [11:0] rgb_out;
    logic        blood_on;
    logic        busy;

    blood_sprite_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .trigger    (trigger),
        .trig_x     (trig_x),
        .trig_y     (trig_y),
        .facing     (facing),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_frame  (rom_frame),
        .rom_data   (rom_data),
        .rgb_out    (rgb_out),
        .blood_on   (blood_on),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: constant colour or an address/frame-dependent pattern.
    logic        rom_mode = 1'b0;
    logic [11:0] rom_const = '0;
    logic        nx_mode = 1'b0;
    logic [11:0] nx_const = '0;

    function automatic logic [11:0] rom_fn(input logic [5:0] r, input logic [5:0] c,
                                           input logic [2:0] f);
        return rom_mode ? ({r, c} ^ {f, 9'd0}) : rom_const;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_row, rom_col, rom_frame);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic        on;
        logic [11:0] rgb;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    // Reference animation state, valid for the cycle after the last edge.
    bit        m_busy = 0;
    logic [9:0] m_px = '0;
    logic [9:0] m_py = '0;
    bit        m_face = 0;
    int        m_frame = 0;
    int        m_hold = 0;

    // Release expected pixels as the DUT reaches them.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            mon_e = q.pop_front();
            chk("blood_on", {31'd0, blood_on}, {31'd0, mon_e.on});
            chk("rgb_out", {20'd0, rgb_out}, {20'd0, mon_e.rgb});
        end
    end

    task automatic step(input bit rst, input logic [9:0] px, input logic [9:0] py,
                        input bit vo, input bit tick, input bit trg,
                        input logic [9:0] tx, input logic [9:0] ty, input bit fc);
        logic       hit;
        logic [5:0] r;
        logic [5:0] c;
        logic [11:0] color;
        logic       on;
        @(posedge clk);
        #1;
        rom_mode = nx_mode;
        rom_const = nx_const;
        reset = rst; x = px; y = py; video_on = vo; frame_tick = tick;
        trigger = trg; trig_x = tx; trig_y = ty; facing = fc;
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("rom_frame", {29'd0, rom_frame}, m_frame);
        hit = m_busy &&
              ({1'b0, px} >= {1'b0, m_px}) && ({1'b0, px} < {1'b0, m_px} + 11'd64) &&
              ({1'b0, py} >= {1'b0, m_py}) && ({1'b0, py} < {1'b0, m_py} + 11'd64);
        r = 6'(py - m_py);
        c = 6'(px - m_px);
`ifdef BLOOD_MIRROR_EN
        if (m_face) c = 6'd63 - c;
`endif
        if (hit) begin
            chk("rom_row", {26'd0, rom_row}, {26'd0, r});
            chk("rom_col", {26'd0, rom_col}, {26'd0, c});
        end
        color = rom_fn(r, c, 3'(m_frame));
        on = hit && vo && (color != 12'h000);
        if (rst) begin
            on = 1'b0;
            foreach (q[i]) if (q[i].due <= cyc + 2) begin q[i].on = 1'b0; q[i].rgb = '0; end
        end
        q.push_back('{cyc + 2, on, on ? color : 12'h000});
        if (rst) begin
            m_busy = 0; m_px = '0; m_py = '0; m_face = 0; m_frame = 0; m_hold = 0;
        end else if (trg) begin
            m_busy = 1; m_px = tx; m_py = ty; m_face = fc; m_frame = 0; m_hold = 0;
        end else if (m_busy && tick) begin
            if (m_hold == 3) begin
                m_hold = 0;
                if (m_frame == 7) begin m_busy = 0; m_frame = 0; end
                else m_frame = m_frame + 1;
            end else begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic pix(input logic [9:0] px, input logic [9:0] py);
        step(0, px, py, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic tick_only();
        step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic trig(input logic [9:0] tx, input logic [9:0] ty, input bit fc, input bit tk);
        step(0, 0, 0, 0, tk, 1, tx, ty, fc);
    endtask

    initial begin
        // Power-on reset and reset-state outputs.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_rgb_out", {20'd0, rgb_out}, 32'd0);
        chk("rst_blood_on", {31'd0, blood_on}, 32'd0);
        chk("rst_rom_row", {26'd0, rom_row}, 32'd0);
        chk("rst_rom_col", {26'd0, rom_col}, 32'd0);
        pix(10, 10);

        // Opaque constant colour at (100,50).
        nx_mode = 0; nx_const = 12'hE00;
        trig(100, 50, 0, 0);
        pix(100, 50);
        pix(163, 113);
        pix(164, 50);
        pix(99, 50);
        pix(100, 114);
        step(0, 110, 60, 0, 0, 0, 0, 0, 0);

        // Transparent colour is never shown.
        nx_const = 12'h000;
        pix(100, 50);
        pix(120, 70);

        // Address-dependent pattern across all frames; finishes after 32 ticks.
        nx_mode = 1;
        pix(110, 60);
        for (int t = 0; t < 32; t++) begin
            tick_only();
            pix(10'(100 + t), 10'(50 + 2 * t));
        end
        pix(110, 60);

        // Retrigger in frame 5 with a same-cycle tick.
        trig(100, 50, 0, 0);
        for (int t = 0; t < 21; t++) tick_only();
        pix(130, 80);
        trig(300, 200, 0, 1);
        pix(300, 200);
        pix(363, 263);
        pix(299, 200);
        pix(130, 80);
        tick_only();
        pix(310, 210);

        // Reset held 3 clocks mid-animation.
        step(1, 310, 210, 1, 0, 0, 0, 0, 0);
        step(1, 320, 220, 1, 1, 0, 0, 0, 0);
        step(1, 330, 230, 1, 0, 0, 0, 0, 0);
        pix(310, 210);

        // Sprite near the right edge: no wrap, optional mirroring.
        trig(1000, 400, 1, 0);
        pix(5, 400);
        pix(1000, 400);
        pix(1010, 410);
        pix(1023, 463);
        pix(1023, 464);
        step(0, 1001, 401, 0, 0, 0, 0, 0, 0);

        pix(0, 0);
        pix(0, 0);
        pix(0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
